// File: rtl/pixel_filter_pkg.sv
// Shared types and constants for the pixel colour filter pipeline.
// Luma coefficients are 8-bit fixed point and sum to 256, so luma never overflows CW bits.
package pixel_filter_pkg;

    typedef enum logic [1:0] {
        PASS   = 2'd0,
        GRAY   = 2'd1,
        INVERT = 2'd2,
        THRESH = 2'd3
    } filt_mode_t;

    localparam int KR     = 77;
    localparam int KG     = 150;
    localparam int KB     = 29;
    localparam int KSHIFT = 8;

    function automatic int pix_w(input int cw);
        return 3 * cw;
    endfunction

endpackage

// File: rtl/luma_calc.sv
// Combinational luma from pre-registered channel products: Y = (pr + pg + pb) >> KSHIFT.
module luma_calc
    import pixel_filter_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW+7:0] prod_r_i,
    input  logic [CW+7:0] prod_g_i,
    input  logic [CW+7:0] prod_b_i,
    output logic [CW-1:0] luma_o
);

    logic [CW+9:0] sum;

    assign sum    = (CW+10)'(prod_r_i) + (CW+10)'(prod_g_i) + (CW+10)'(prod_b_i);
    assign luma_o = CW'(sum >> KSHIFT);

endmodule

// File: rtl/pixel_filter_pipe.sv
// Two-stage per-pixel colour filter (pass / gray / invert / threshold) with valid/ready
// handshake; mode, threshold and frame tags travel alongside each pixel.
module pixel_filter_pipe
    import pixel_filter_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [CW-1:0]          thresh,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [pix_w(CW)-1:0]   in_pixel,
    input  logic                   in_sof,
    input  logic                   in_eol,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [pix_w(CW)-1:0]   out_pixel,
    output logic                   out_sof,
    output logic                   out_eol
);

    localparam int PW = pix_w(CW);
    localparam int MW = CW + 8;

    logic          en;
    logic          acc;
    logic [MW-1:0] prod_r_d, prod_g_d, prod_b_d;

    logic          vld_p1_q;
    logic [MW-1:0] prod_r_p1_q, prod_g_p1_q, prod_b_p1_q;
    logic [PW-1:0] pix_p1_q;
    filt_mode_t    mode_p1_q;
    logic [CW-1:0] thr_p1_q;
    logic          sof_p1_q, eol_p1_q;

    logic [CW-1:0] luma;
    logic [PW-1:0] res_d;

    logic          vld_p2_q;
    logic [PW-1:0] pix_p2_q;
    logic          sof_p2_q, eol_p2_q;

    // Both stages move together; a stalled output freezes the whole pipe.
    assign en       = out_ready || !vld_p2_q;
    assign in_ready = en && rst_n;
    assign acc      = in_valid && in_ready;

    assign prod_r_d = MW'(KR) * MW'(in_pixel[3*CW-1:2*CW]);
    assign prod_g_d = MW'(KG) * MW'(in_pixel[2*CW-1:CW]);
    assign prod_b_d = MW'(KB) * MW'(in_pixel[CW-1:0]);

    // ---- stage 1: products, raw pixel and per-pixel settings ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else if (en) begin
            vld_p1_q <= acc;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            prod_r_p1_q <= prod_r_d;
            prod_g_p1_q <= prod_g_d;
            prod_b_p1_q <= prod_b_d;
            pix_p1_q    <= in_pixel;
            mode_p1_q   <= filt_mode_t'(mode);
            thr_p1_q    <= thresh;
            sof_p1_q    <= in_sof;
            eol_p1_q    <= in_eol;
        end
    end

    luma_calc #(.CW(CW)) u_luma (
        .prod_r_i (prod_r_p1_q),
        .prod_g_i (prod_g_p1_q),
        .prod_b_i (prod_b_p1_q),
        .luma_o   (luma)
    );

    always_comb begin
        res_d = pix_p1_q;
        case (mode_p1_q)
            PASS:   res_d = pix_p1_q;
            GRAY:   res_d = {3{luma}};
            INVERT: res_d = ~pix_p1_q;
            THRESH: res_d = (luma >= thr_p1_q) ? {PW{1'b1}} : {PW{1'b0}};
        endcase
    end

    // ---- stage 2: selected result, drives the output ports ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2_q <= 1'b0;
            pix_p2_q <= '0;
            sof_p2_q <= 1'b0;
            eol_p2_q <= 1'b0;
        end else if (en) begin
            vld_p2_q <= vld_p1_q;
            pix_p2_q <= res_d;
            sof_p2_q <= sof_p1_q;
            eol_p2_q <= eol_p1_q;
        end
    end

    assign out_valid = vld_p2_q;
    assign out_pixel = pix_p2_q;
    assign out_sof   = sof_p2_q;
    assign out_eol   = eol_p2_q;

endmodule

// File: tb/tb_pixel_filter_pipe.sv
// Randomised and directed bench for pixel_filter_pipe with a transaction-level reference model.
module tb_pixel_filter_pipe;

    localparam int CW = 8;
    localparam int PW = 3 * CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic [CW-1:0] thresh;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pixel;
    logic          in_sof;
    logic          in_eol;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pixel;
    logic          out_sof;
    logic          out_eol;

    pixel_filter_pipe #(.CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .thresh    (thresh),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pix;
        logic          sof;
        logic          eol;
        int            acyc;
    } item_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    item_t         expq[$];
    logic [PW-1:0] olog[$];
    int            ocyc[$];
    int            alog[$];
    logic          held_v = 1'b0;
    logic [PW-1:0] held_pix;
    logic          held_sof, held_eol;
    logic          rnd_on = 1'b0;

    always @(posedge clk) cyc++;

    function automatic logic [PW-1:0] ref_pix(input logic [PW-1:0] p, input logic [1:0] m,
                                               input logic [CW-1:0] t);
        int r, g, b, y;
        logic [CW-1:0] y8;
        r  = int'(p[23:16]);
        g  = int'(p[15:8]);
        b  = int'(p[7:0]);
        y  = (77 * r + 150 * g + 29 * b) / 256;
        y8 = y[7:0];
        case (m)
            2'd0:    return p;
            2'd1:    return {y8, y8, y8};
            2'd2:    return ~p;
            default: return (y >= int'(t)) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle compare process: scoreboard, hold-stability and handshake rule.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
            expq.delete();
            held_v = 1'b0;
        end else begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (out_ready || !out_valid)});
            if (held_v) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_pixel", {8'd0, out_pixel}, {8'd0, held_pix});
                chk("hold_tags", {30'd0, out_sof, out_eol}, {30'd0, held_sof, held_eol});
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=none", out_pixel);
                end else begin
                    item_t it;
                    it = expq.pop_front();
                    chk("out_pixel", {8'd0, out_pixel}, {8'd0, it.pix});
                    chk("out_tags", {30'd0, out_sof, out_eol}, {30'd0, it.sof, it.eol});
                    olog.push_back(out_pixel);
                    ocyc.push_back(cyc);
                    alog.push_back(it.acyc);
                end
            end
            held_v   = out_valid && !out_ready;
            held_pix = out_pixel;
            held_sof = out_sof;
            held_eol = out_eol;
            if (in_valid && in_ready)
                expq.push_back('{ref_pix(in_pixel, mode, thresh), in_sof, in_eol, cyc});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_on) out_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [PW-1:0] p, input logic [1:0] m, input logic [CW-1:0] t,
                        input logic sof, input logic eol);
        in_pixel = p;
        mode     = m;
        thresh   = t;
        in_sof   = sof;
        in_eol   = eol;
        in_valid = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            #2;
            if (expq.size() == 0 && !out_valid) return;
        end
        chk("drain_timeout", expq.size(), 32'd0);
    endtask

    task automatic clear_log();
        olog.delete();
        ocyc.delete();
        alog.delete();
    endtask

    initial begin
        logic [PW-1:0] rp;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 2'd0;
        thresh    = '0;
        in_pixel  = '0;
        in_sof    = 1'b0;
        in_eol    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_pixel", {8'd0, out_pixel}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Model pinned against hand-computed values.
        chk("model_gray", {8'd0, ref_pix(24'hFF0000, 2'd1, 8'h00)}, 32'h004C4C4C);
        chk("model_inv", {8'd0, ref_pix(24'h123456, 2'd2, 8'h00)}, 32'h00EDCBA9);
        chk("model_thr", {8'd0, ref_pix(24'h7F7F7F, 2'd3, 8'h80)}, 32'h00000000);

        // GRAY stream, latency and back-to-back throughput.
        clear_log();
        send(24'hFF0000, 2'd1, 8'h00, 1'b1, 1'b0);
        send(24'hFFFFFF, 2'd1, 8'h00, 1'b0, 1'b0);
        send(24'h000000, 2'd1, 8'h00, 1'b0, 1'b1);
        drain();
        chk("gray_count", olog.size(), 32'd3);
        if (olog.size() == 3) begin
            chk("gray_0", {8'd0, olog[0]}, 32'h004C4C4C);
            chk("gray_1", {8'd0, olog[1]}, 32'h00FFFFFF);
            chk("gray_2", {8'd0, olog[2]}, 32'h00000000);
            chk("latency", ocyc[0] - alog[0], 32'd2);
            chk("consecutive_1", ocyc[1] - ocyc[0], 32'd1);
            chk("consecutive_2", ocyc[2] - ocyc[1], 32'd1);
        end

        // INVERT / PASS / THRESH with threshold changing per pixel.
        clear_log();
        send(24'h123456, 2'd2, 8'h00, 1'b0, 1'b0);
        send(24'h123456, 2'd0, 8'h00, 1'b0, 1'b0);
        send(24'h808080, 2'd3, 8'h80, 1'b0, 1'b0);
        send(24'h7F7F7F, 2'd3, 8'h80, 1'b0, 1'b0);
        send(24'h000000, 2'd3, 8'h00, 1'b0, 1'b1);
        drain();
        chk("modes_count", olog.size(), 32'd5);
        if (olog.size() == 5) begin
            chk("invert", {8'd0, olog[0]}, 32'h00EDCBA9);
            chk("pass", {8'd0, olog[1]}, 32'h00123456);
            chk("thr_hi", {8'd0, olog[2]}, 32'h00FFFFFF);
            chk("thr_lo", {8'd0, olog[3]}, 32'h00000000);
            chk("thr_zero", {8'd0, olog[4]}, 32'h00FFFFFF);
        end

        // Backpressure with a full pipe.
        clear_log();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(24'h010101 * (i + 1), 2'd0, 8'h00, i == 0, (i % 5) == 4);
            end
            begin
                int w;
                w = 0;
                while (!out_valid && w < 100) begin
                    @(posedge clk);
                    #2;
                    w++;
                end
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                @(posedge clk);
                #1;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("bp_first_pixel", {8'd0, out_pixel}, 32'h00010101);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", olog.size(), 32'd10);
        for (int i = 0; i < 10; i++)
            if (i < olog.size()) chk("bp_order", {8'd0, olog[i]}, 32'h00010101 * (i + 1));

        // Randomised traffic with per-pixel mode/threshold changes.
        clear_log();
        rnd_on = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if (($urandom % 4) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            rp = PW'($urandom);
            send(rp, 2'($urandom), CW'($urandom), ($urandom % 16) == 0, ($urandom % 8) == 0);
        end
        @(posedge clk);
        #1;
        rnd_on    = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("random_count", olog.size(), 32'd10000);

        // Reset with two pixels in flight.
        clear_log();
        out_ready = 1'b0;
        send(24'hAAAAAA, 2'd0, 8'h00, 1'b1, 1'b0);
        send(24'hBBBBBB, 2'd0, 8'h00, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pixel", {8'd0, out_pixel}, 32'd0);
        chk("rst_out_tags", {30'd0, out_sof, out_eol}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_no_output", {31'd0, out_valid}, 32'd0);
        end
        chk("rst_log_empty", olog.size(), 32'd0);
        chk("final_queue_empty", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_filter_pipe.md
# pixel_filter_pipe

Parametrised, pipelined per-pixel colour filter for the VGA serial display path. It sits between the frame-buffer read side and the VGA pixel output. It generalises the switch-selected grayscale converter in four ways:
- configurable channel width;
- four runtime-selectable modes: pass, gray, invert, threshold;
- integer-exact luma arithmetic;
- a valid/ready handshake with backpressure and pass-through frame sideband.

## Interface
- `CW`, default 8: bits per colour channel; the pixel is 3*CW bits, packed {R,G,B} with R in [3*CW-1:2*CW] and B in [CW-1:0].
- `clk`  in  1  system clock; everything is synchronous to its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `mode`  in  2  0 = PASS, 1 = GRAY, 2 = INVERT, 3 = THRESH; sampled together with each accepted pixel.
- `thresh`  in  CW  threshold level for THRESH; sampled together with each accepted pixel.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  block can accept a pixel this cycle.
- `in_pixel`  in  3*CW  input pixel.
- `in_sof`  in  1  start-of-frame tag for the pixel.
- `in_eol`  in  1  end-of-line tag for the pixel.
- `out_valid`  out  1  output pixel valid.
- `out_ready`  in  1  downstream accepts the output pixel.
- `out_pixel`  out  3*CW  filtered pixel.
- `out_sof`  out  1  sof tag delayed with its pixel.
- `out_eol`  out  1  eol tag delayed with its pixel.

## Operation
- Luma: Y = (77*R + 150*G + 29*B) >> 8.
  - Products are CW+8 bits wide; the sum is CW+10 bits wide.
  - The coefficients sum to 256, so Y is at most 2^CW-1. No saturation logic is needed; take the truncated low CW bits after the shift.
- PASS: out = in.
- GRAY: out = {Y,Y,Y}.
- INVERT: each channel is the bitwise complement.
- THRESH: out = all ones if Y >= thresh, otherwise all zeros. The comparison is unsigned.
- `mode`, `thresh`, `sof` and `eol` travel with their pixel through the pipe. A mode change mid-stream affects only pixels accepted after the change; no pixel is ever processed with mixed settings.
- A transfer occurs on a side when valid && ready is high at the rising clock edge. Each pixel is emitted exactly once and in order.
- No pixel is dropped or duplicated under any pattern of `in_valid` or `out_ready`.

## Timing
- Two register stages:
  - S1 registers the three products, the raw pixel, `mode`, `thresh` and the tags.
  - S2 registers the selected result and drives the `out_*` ports directly.
- Latency is 2 cycles from input acceptance to `out_valid`, when not stalled.
- Throughput is 1 pixel per cycle while `out_ready` = 1.
- Pipe enable: `en` = `out_ready` || !`s2_valid`. Both stages advance only when `en` = 1, and `in_ready` = `en`.
  - An S1 bubble behind a stalled S2 is not collapsed; this is accepted.
- While `out_valid` = 1 and `out_ready` = 0, `out_pixel`, `out_sof` and `out_eol` hold stable.
- On the cycle `rst_n` is sampled low:
  - `out_valid`, `out_pixel`, `out_sof` and `out_eol` go to 0, and both stage valids clear.
  - `in_ready` is forced to 0 while `rst_n` is low, and is 1 on the first cycle after release.
- Reset mid-stream discards every in-flight pixel; nothing partial is emitted afterwards.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.

## Structure
- `pixel_filter_pkg`:
  - `filt_mode_t` enum (PASS, GRAY, INVERT, THRESH);
  - localparams `KR` = 77, `KG` = 150, `KB` = 29, `KSHIFT` = 8;
  - the pixel width function 3*CW.
- Sub-module `luma_calc` (parameter `CW`): combinational sum of registered products plus shift, producing Y. It is used by S2 for both GRAY and THRESH.
- The top level holds the handshake, the two stage registers and the mode mux.

## Test plan
- Reset, `CW`=8, GRAY, then stream FF0000, FFFFFF, 000000 with `out_ready`=1 -> outputs 4C4C4C, FFFFFF, 000000 on consecutive cycles, first output 2 cycles after the first acceptance.
- INVERT, 123456 -> EDCBA9; PASS, 123456 -> 123456.
- THRESH with `thresh`=80: 808080 -> FFFFFF, 7F7F7F -> 000000. Changing `thresh` to 00 on the next pixel gives 000000 -> FFFFFF, and the earlier pixels are unaffected.
- Backpressure: hold `out_ready`=0 for 5 cycles with the pipe full -> `in_ready`=0, and `out_pixel` is stable and equal to the first pixel. After release, 10 pixels emerge in order with none lost or duplicated, and the `sof`/`eol` tags stay aligned.
- Random `in_valid` and `out_ready` for 10k pixels, with the mode changing per pixel -> scoreboard matches the reference model exactly.
- Assert `rst_n`=0 for 1 cycle with 2 pixels in flight -> `out_valid`=0 on the next cycle, neither pixel ever appears, and `in_ready`=1 afterwards.
